// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the screen-write command UART link.
// Frame layout: column, row, ASCII char, newline.
package uart_cmd_pkg;

  localparam logic [7:0]  CMD_NEWLINE     = 8'h0A;
  localparam int unsigned CMD_FRAME_BYTES = 4;
  localparam int unsigned NCOL            = 80;
  localparam int unsigned NROW            = 30;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start pulse is honoured in any state, so the next byte
// can begin on the last stop-bit cycle (flagged by done) with no idle gap.
module uart_tx_byte
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign done      = (r_state == StStop) && w_bit_end;
  assign tx        = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (start) begin
      r_state <= StStart;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= data;
      r_tx    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: r_tx <= 1'b1;
        StStart: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= StData;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= StStop;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= StIdle;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// Screen-write command transmitter: accepts one (col, row, char) command per
// valid/ready handshake and sends it as four back-to-back 8N1 bytes.
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_col,
  input  logic [4:0] req_row,
  input  logic [6:0] req_char,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [1:0]  LAST_BYTE    = 2'(CMD_FRAME_BYTES - 1);

  logic       r_idle;
  logic       r_busy;
  logic [1:0] r_byte_idx;
  logic [6:0] r_col;
  logic [4:0] r_row;
  logic [6:0] r_char;

  logic       w_accept;
  logic       w_done;
  logic       w_last;
  logic       w_next;
  logic       w_start;
  logic [1:0] w_sel;
  logic [7:0] w_data;

  assign w_accept  = req_valid && req_ready;
  assign w_last    = (r_byte_idx == LAST_BYTE);
  assign w_next    = w_done && !w_last;
  assign w_start   = w_accept || w_next;
  // Byte 0 goes out straight from the inputs on the accept edge.
  assign w_sel     = w_accept ? 2'd0 : r_byte_idx + 2'd1;
  assign req_ready = r_idle && !rst;
  assign busy      = r_busy;

  always_comb begin
    w_data = CMD_NEWLINE;
    case (w_sel)
      2'd0:    w_data = {1'b0, req_col};
      2'd1:    w_data = {3'b000, r_row};
      2'd2:    w_data = {1'b0, r_char};
      default: w_data = CMD_NEWLINE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle     <= 1'b1;
      r_busy     <= 1'b0;
      r_byte_idx <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_char     <= '0;
    end else if (w_accept) begin
      r_idle     <= 1'b0;
      r_busy     <= 1'b1;
      r_byte_idx <= '0;
      r_col      <= req_col;
      r_row      <= req_row;
      r_char     <= req_char;
    end else if (w_done) begin
      if (w_last) begin
        r_idle     <= 1'b1;
        r_busy     <= 1'b0;
        r_byte_idx <= '0;
      end else begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .data (w_data),
    .tx   (tx),
    .done (w_done)
  );

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Bench for uart_cmd_tx: a frame-level model queues expected bytes and their start
// times on each accepted command; a line decoder on tx pops and compares them.
module tb_uart_cmd_tx;

  localparam int unsigned CLK_FREQ = 1300000;
  localparam int unsigned BAUD     = 100000;
  localparam int          CPB      = 13;
  localparam int          FRAME    = 40 * CPB;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_col;
  logic [4:0] req_row;
  logic [6:0] req_char;
  logic       tx;
  logic       busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  // Model state
  int acc_at  = 0;
  int free_at = 0;
  bit prev_rst = 1'b0;

  // Monitor state
  bit         mon_active = 1'b0;
  int         mon_start;
  int         mon_t;
  logic [7:0] mon_byte;
  logic       mon_sbit;

  uart_cmd_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_col  (req_col),
    .req_row  (req_row),
    .req_char (req_char),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Reference model: a frame occupies the line for 40 bit times after acceptance.
  always @(negedge clk) begin
    bit ready_exp;
    bit busy_exp;
    logic [7:0] b[4];
    if (rst) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      if (prev_rst) begin
        chk("busy_in_reset", 32'(busy), 32'd0);
        chk("tx_in_reset", 32'(tx), 32'd1);
      end
      exp_q.delete();
      acc_at  = 0;
      free_at = 0;
    end else begin
      ready_exp = (cyc >= free_at);
      busy_exp  = (cyc > acc_at) && (cyc < free_at);
      chk("ready", 32'(req_ready), 32'(ready_exp));
      chk("busy", 32'(busy), 32'(busy_exp));
      if (req_valid && ready_exp) begin
        b[0] = 8'(req_col);
        b[1] = 8'(req_row);
        b[2] = 8'(req_char);
        b[3] = 8'h0A;
        for (int k = 0; k < 4; k++) exp_q.push_back('{b[k], cyc + 1 + k * 10 * CPB});
        acc_at  = cyc;
        free_at = cyc + 1 + FRAME;
      end
    end
    prev_rst = rst;
  end

  // Line monitor: decodes 8N1 by sampling each bit at its midpoint.
  always @(negedge clk) begin
    int j;
    exp_t e;
    if (rst) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      mon_t++;
      if (mon_t % CPB == CPB / 2) begin
        j = mon_t / CPB;
        if (j == 0) mon_sbit = tx;
        else if (j <= 8) mon_byte[j-1] = tx;
        else begin
          mon_active = 1'b0;
          chk("stop_bit", 32'(tx), 32'd1);
          chk("start_bit", 32'(mon_sbit), 32'd0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte at cyc %0d: got %0h, required none", cyc, mon_byte);
          end else begin
            e = exp_q.pop_front();
            chk("byte_value", 32'(mon_byte), 32'(e.data));
            chk("byte_start_cyc", 32'(mon_start), 32'(e.at));
          end
        end
      end
    end else if (tx === 1'b0) begin
      mon_active = 1'b1;
      mon_start  = cyc;
      mon_t      = 0;
    end
  end

  task automatic issue(input logic [6:0] c, input logic [4:0] r, input logic [6:0] ch,
                       input bit hold);
    int n;
    req_col   = c;
    req_row   = r;
    req_char  = ch;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100 * CPB);
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: ready=%0b, required 1", req_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic junk_pulse(input int delay);
    repeat (delay) @(posedge clk);
    #1;
    req_col   = 7'd1;
    req_row   = 5'd1;
    req_char  = 7'h31;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    bit hold;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_col   = '0;
    req_row   = '0;
    req_char  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(7'd5, 5'd3, 7'h41, 1'b0);
    junk_pulse(100);
    repeat (FRAME) @(posedge clk);
    #1;

    // Two contiguous frames with valid held high throughout.
    issue(7'd79, 5'd29, 7'h7E, 1'b1);
    issue(7'd0, 5'd0, 7'h20, 1'b0);
    repeat (FRAME + 5) @(posedge clk);
    #1;

    issue(7'd85, 5'd4, 7'h5A, 1'b0);
    repeat (FRAME + 3) @(posedge clk);
    #1;

    // Reset lands in the data bits of B1.
    issue(7'd10, 5'd7, 7'h48, 1'b0);
    repeat (13 * CPB) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    issue(7'd2, 5'd2, 7'h42, 1'b0);
    repeat (FRAME + 3) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      hold = ($urandom_range(0, 1) == 1);
      issue(7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
            7'($urandom_range(0, 127)), hold);
      if (!hold) begin
        if ($urandom_range(0, 1) == 1) junk_pulse($urandom_range(20, 400));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;

    repeat (2 * FRAME) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("monitor_idle", 32'(mon_active), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
